// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - tile sequencer for the 4x4 weight-stationary systolic array
// Optional feature macro: SYSTOLIC_CTRL_PERF_EN adds perf_cycles (accept-to-done cycle count).
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int VEC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  // tile command
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [VEC_W-1:0]   cmd_num_vec,
  input  logic [2:0]         cmd_col_size,
  // weight row stream
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [16*N-1:0]    w_data,
  // input vector stream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [16*N-1:0]    in_data,
  // array top edge
  output logic [15:0]        sys_weight_in_11,
  output logic [15:0]        sys_weight_in_12,
  output logic [15:0]        sys_weight_in_13,
  output logic [15:0]        sys_weight_in_14,
  output logic               sys_accept_w_1,
  output logic               sys_accept_w_2,
  output logic               sys_accept_w_3,
  output logic               sys_accept_w_4,
  output logic               sys_switch_in,
  // array left edge
  output logic [15:0]        sys_data_in_11,
  output logic [15:0]        sys_data_in_21,
  output logic [15:0]        sys_data_in_31,
  output logic [15:0]        sys_data_in_41,
  output logic               sys_start_1,
  output logic               sys_start_2,
  output logic               sys_start_3,
  output logic               sys_start_4,
  // array bottom edge
  input  logic [N-1:0]       sys_valid_out_4,
  // array configuration
  output logic [15:0]        ub_rd_col_size_out,
  output logic               ub_rd_col_size_valid_out,
  // status
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic [31:0]        perf_cycles,
`endif
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD_W,
    S_SWITCH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_num_vec;
  logic [1:0]         r_col_idx;      // col_size-1: which bottom-row valid bit to count
  logic [2:0]         r_w_cnt;
  logic [VEC_W-1:0]   r_iss_cnt;
  logic [VEC_W-1:0]   r_res_cnt;
  logic               r_cmd_ready;
  logic               r_w_ready;
  logic               r_in_ready;
  logic               r_cfg_vld;
  logic [15:0]        r_col_out;
  logic               r_switch;
  logic               r_done;
  logic               r_err;
  logic [N-1:0]       r_accept_w;
  logic [16*N-1:0]    r_weight;

  // skew pipeline: stage 0 holds the whole accepted vector, deeper rows add delay
  logic [16*N-1:0]    r_s0_data;
  logic               r_s0_vld;
  logic [15:0]        r_r2_d;
  logic               r_r2_v;
  logic [15:0]        r_r3_d [2];
  logic [1:0]         r_r3_v;
  logic [15:0]        r_r4_d [3];
  logic [2:0]         r_r4_v;

  logic               w_cmd_acc;
  logic               w_col_ok;
  logic               w_w_beat;
  logic               w_in_beat;
  logic               w_res_hit;
  logic [VEC_W-1:0]   w_res_next;
  logic [VEC_W-1:0]   w_iss_next;

  assign w_cmd_acc  = cmd_valid && r_cmd_ready;
  assign w_col_ok   = (cmd_col_size != 3'd0) && (cmd_col_size <= 3'd4);
  assign w_w_beat   = w_valid && r_w_ready;
  assign w_in_beat  = in_valid && r_in_ready;
  // once the count reaches num_vec further pulses are ignored
  assign w_res_hit  = (r_state == S_DRAIN) && sys_valid_out_4[r_col_idx] &&
                      (r_res_cnt != r_num_vec);
  assign w_res_next = r_res_cnt + {{(VEC_W-1){1'b0}}, w_res_hit};
  assign w_iss_next = r_iss_cnt + {{(VEC_W-1){1'b0}}, 1'b1};

  // tile sequencer: state, counters and all registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num_vec   <= '0;
      r_col_idx   <= '0;
      r_w_cnt     <= '0;
      r_iss_cnt   <= '0;
      r_res_cnt   <= '0;
      r_cmd_ready <= 1'b1;
      r_w_ready   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_cfg_vld   <= 1'b0;
      r_col_out   <= '0;
      r_switch    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_accept_w  <= '0;
      r_weight    <= '0;
    end else begin
      r_cfg_vld  <= 1'b0;
      r_switch   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_accept_w <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            if (w_col_ok) begin
              r_num_vec   <= cmd_num_vec;
              r_col_idx   <= cmd_col_size[1:0] - 2'd1;
              r_col_out   <= {13'd0, cmd_col_size};
              r_cfg_vld   <= 1'b1;
              r_cmd_ready <= 1'b0;
              r_state     <= S_CFG;
            end else begin
              // illegal column count: flag it and stay idle, array untouched
              r_err <= 1'b1;
            end
          end
        end
        S_CFG: begin
          r_w_cnt   <= '0;
          r_w_ready <= 1'b1;
          r_state   <= S_LOAD_W;
        end
        S_LOAD_W: begin
          if (w_w_beat) begin
            r_weight   <= w_data;
            r_accept_w <= '1;
            r_w_cnt    <= r_w_cnt + 3'd1;
            if (r_w_cnt == 3'd3) begin
              r_w_ready <= 1'b0;
              r_state   <= S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          // the fourth weight row is shifting in this cycle; switch afterwards
          r_switch  <= 1'b1;
          r_iss_cnt <= '0;
          r_res_cnt <= '0;
          if (r_num_vec == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_in_beat) begin
            r_iss_cnt <= w_iss_next;
            if (w_iss_next == r_num_vec) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_res_cnt <= w_res_next;
          if (w_res_next == r_num_vec) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_w_ready   <= 1'b0;
          r_in_ready  <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // input skew: row r leaves r-1 cycles after row 1, start bits travel alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_data <= '0;
      r_s0_vld  <= 1'b0;
      r_r2_d    <= '0;
      r_r2_v    <= 1'b0;
      r_r3_d[0] <= '0;
      r_r3_d[1] <= '0;
      r_r3_v    <= '0;
      r_r4_d[0] <= '0;
      r_r4_d[1] <= '0;
      r_r4_d[2] <= '0;
      r_r4_v    <= '0;
    end else begin
      // bubbles hold the last vector so the array sees stable data with start=0
      r_s0_vld <= w_in_beat;
      if (w_in_beat) begin
        r_s0_data <= in_data;
      end
      r_r2_d    <= r_s0_data[31:16];
      r_r2_v    <= r_s0_vld;
      r_r3_d[0] <= r_s0_data[47:32];
      r_r3_d[1] <= r_r3_d[0];
      r_r3_v    <= {r_r3_v[0], r_s0_vld};
      r_r4_d[0] <= r_s0_data[63:48];
      r_r4_d[1] <= r_r4_d[0];
      r_r4_d[2] <= r_r4_d[1];
      r_r4_v    <= {r_r4_v[1:0], r_s0_vld};
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_perf;
  logic        r_perf_run;

  // accept-to-done cycle counter, inclusive of both ends, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf     <= '0;
      r_perf_run <= 1'b0;
    end else if (w_cmd_acc && w_col_ok) begin
      r_perf     <= 32'd1;
      r_perf_run <= 1'b1;
    end else if (w_cmd_acc) begin
      r_perf     <= '0;
      r_perf_run <= 1'b0;
    end else if (r_perf_run) begin
      if (r_perf != 32'hFFFF_FFFF) begin
        r_perf <= r_perf + 32'd1;
      end
      if (r_done) begin
        r_perf_run <= 1'b0;
      end
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign cmd_ready                = r_cmd_ready;
  assign w_ready                  = r_w_ready;
  assign in_ready                 = r_in_ready;
  assign sys_weight_in_11         = r_weight[15:0];
  assign sys_weight_in_12         = r_weight[31:16];
  assign sys_weight_in_13         = r_weight[47:32];
  assign sys_weight_in_14         = r_weight[63:48];
  assign sys_accept_w_1           = r_accept_w[0];
  assign sys_accept_w_2           = r_accept_w[1];
  assign sys_accept_w_3           = r_accept_w[2];
  assign sys_accept_w_4           = r_accept_w[3];
  assign sys_switch_in            = r_switch;
  assign sys_data_in_11           = r_s0_data[15:0];
  assign sys_data_in_21           = r_r2_d;
  assign sys_data_in_31           = r_r3_d[1];
  assign sys_data_in_41           = r_r4_d[2];
  assign sys_start_1              = r_s0_vld;
  assign sys_start_2              = r_r2_v;
  assign sys_start_3              = r_r3_v[1];
  assign sys_start_4              = r_r4_v[2];
  assign ub_rd_col_size_out       = r_col_out;
  assign ub_rd_col_size_valid_out = r_cfg_vld;
  assign done                     = r_done;
  assign err                      = r_err;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - randomized self-checking bench for systolic_ctrl
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_num_vec = '0;
  logic [2:0]  cmd_col_size = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [63:0] w_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [15:0] sys_weight_in_11, sys_weight_in_12, sys_weight_in_13, sys_weight_in_14;
  logic        sys_accept_w_1, sys_accept_w_2, sys_accept_w_3, sys_accept_w_4;
  logic        sys_switch_in;
  logic [15:0] sys_data_in_11, sys_data_in_21, sys_data_in_31, sys_data_in_41;
  logic        sys_start_1, sys_start_2, sys_start_3, sys_start_4;
  logic [3:0]  sys_valid_out_4 = '0;
  logic [15:0] ub_rd_col_size_out;
  logic        ub_rd_col_size_valid_out;
  logic        done;
  logic        err;

  systolic_ctrl #(.N(4), .VEC_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num_vec(cmd_num_vec), .cmd_col_size(cmd_col_size),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sys_weight_in_11(sys_weight_in_11), .sys_weight_in_12(sys_weight_in_12),
    .sys_weight_in_13(sys_weight_in_13), .sys_weight_in_14(sys_weight_in_14),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_accept_w_3(sys_accept_w_3), .sys_accept_w_4(sys_accept_w_4),
    .sys_switch_in(sys_switch_in),
    .sys_data_in_11(sys_data_in_11), .sys_data_in_21(sys_data_in_21),
    .sys_data_in_31(sys_data_in_31), .sys_data_in_41(sys_data_in_41),
    .sys_start_1(sys_start_1), .sys_start_2(sys_start_2),
    .sys_start_3(sys_start_3), .sys_start_4(sys_start_4),
    .sys_valid_out_4(sys_valid_out_4),
    .ub_rd_col_size_out(ub_rd_col_size_out),
    .ub_rd_col_size_valid_out(ub_rd_col_size_valid_out),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model state: weights last loaded, expected row outputs keyed by cycle
  logic [63:0] cur_w = '0;
  logic [15:0] exp_map [int];
  logic [15:0] last_d [4];
  logic        mon_en = 1'b0;

  wire [3:0]  st_v = {sys_start_4, sys_start_3, sys_start_2, sys_start_1};
  wire [63:0] dat_v = {sys_data_in_41, sys_data_in_31, sys_data_in_21, sys_data_in_11};
  wire [3:0]  acc_w = {sys_accept_w_4, sys_accept_w_3, sys_accept_w_2, sys_accept_w_1};
  wire [63:0] wts_v = {sys_weight_in_14, sys_weight_in_13, sys_weight_in_12, sys_weight_in_11};

  // row monitor: row r of a vector accepted on the edge ending cycle c shows at cycle c+1+r
  always @(negedge clk) begin
    if (mon_en) begin
      for (int r = 0; r < 4; r++) begin
        int key;
        key = cyc * 4 + r;
        if (exp_map.exists(key)) begin
          check_eq($sformatf("start_row%0d", r + 1), st_v[r], 1'b1);
          check_eq($sformatf("data_row%0d", r + 1), dat_v[16*r +: 16], exp_map[key]);
          last_d[r] = exp_map[key];
          exp_map.delete(key);
        end else begin
          check_eq($sformatf("idle_start_row%0d", r + 1), st_v[r], 1'b0);
          check_eq($sformatf("hold_row%0d", r + 1), dat_v[16*r +: 16], last_d[r]);
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    w_valid  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_start", st_v, 4'h0);
    check_eq("rst_data", dat_v, 64'h0);
    check_eq("rst_accept_w", acc_w, 4'h0);
    check_eq("rst_switch", sys_switch_in, 1'b0);
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_done", done, 1'b0);
    mon_en = 1'b0;
    exp_map.delete();
    for (int r = 0; r < 4; r++) last_d[r] = '0;
    cur_w = '0;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_done", done, 1'b0);
      check_eq("post_rst_cmd_ready", cmd_ready, 1'b1);
    end
  endtask

  task automatic bad_cmd(input int col);
    cmd_valid    = 1'b1;
    cmd_col_size = 3'(col);
    cmd_num_vec  = 16'($urandom_range(0, 5));
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("bad_err", err, 1'b1);
    check_eq("bad_cfg", ub_rd_col_size_valid_out, 1'b0);
    check_eq("bad_cmd_ready", cmd_ready, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_eq("bad_err_clear", err, 1'b0);
      check_eq("bad_accept_w", acc_w, 4'h0);
      check_eq("bad_switch", sys_switch_in, 1'b0);
      check_eq("bad_cfg_later", ub_rd_col_size_valid_out, 1'b0);
      check_eq("bad_w_ready", w_ready, 1'b0);
    end
  endtask

  // wmode: 0 directed weights no gaps, 1 directed weights gapped 1,0,1,1,0,1, 2 random
  // igap: percent bubble chance, or -1 for a single bubble on the second slot
  task automatic run_tile(input int col, input int nv, input int wmode, input int igap,
                          input int rst_after);
    logic [63:0] wrow [4];
    logic [5:0]  pat;
    logic        bitv;
    int          beats, acc, pulses, sw_cyc, done_at, t;
    pat = 6'b101101;
    for (int b = 0; b < 4; b++)
      wrow[b] = (wmode == 2) ? {$urandom, $urandom} : {4{16'(b + 1)}};
    cmd_valid    = 1'b1;
    cmd_col_size = 3'(col);
    cmd_num_vec  = 16'(nv);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("cfg_strobe", ub_rd_col_size_valid_out, 1'b1);
    check_eq("cfg_col", ub_rd_col_size_out, 16'(col));
    check_eq("cmd_ready_busy", cmd_ready, 1'b0);
    check_eq("cfg_err", err, 1'b0);
    check_eq("cfg_w_ready", w_ready, 1'b0);
    @(negedge clk);
    check_eq("cfg_strobe_once", ub_rd_col_size_valid_out, 1'b0);
    beats = 0;
    for (t = 0; t < 100; t++) begin
      check_eq("w_ready", w_ready, beats < 4);
      check_eq("weights", wts_v, cur_w);
      check_eq("in_ready_load", in_ready, 1'b0);
      check_eq("switch_load", sys_switch_in, 1'b0);
      if (t > 0) check_eq("accept_w", acc_w, w_valid ? 4'hF : 4'h0);
      if (beats == 4) break;
      case (wmode)
        0:       w_valid = 1'b1;
        1:       w_valid = (t < 6) ? pat[t] : 1'b1;
        default: w_valid = (t > 40) || ($urandom_range(0, 2) != 0);
      endcase
      w_data   = wrow[beats];
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      if (w_valid) begin
        cur_w = wrow[beats];
        beats++;
      end
      @(negedge clk);
    end
    check_eq("load_timeout", t < 100, 1'b1);
    w_valid  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    sw_cyc = cyc;
    check_eq("switch", sys_switch_in, 1'b1);
    check_eq("accept_w_after", acc_w, 4'h0);
    check_eq("in_ready_sw", in_ready, nv > 0);
    acc = 0;
    for (t = 0; acc < nv && t < 200; t++) begin
      check_eq("in_ready", in_ready, 1'b1);
      check_eq("w_ready_stream", w_ready, 1'b0);
      check_eq("accept_w_stream", acc_w, 4'h0);
      check_eq("switch_once", sys_switch_in, cyc == sw_cyc);
      check_eq("done_stream", done, 1'b0);
      if (igap < 0) in_valid = (t != 1);
      else          in_valid = (t > 50) || ($urandom_range(0, 99) >= igap);
      in_data = {$urandom, $urandom};
      w_valid = 1'($urandom);
      if (in_valid) begin
        for (int r = 0; r < 4; r++) exp_map[(cyc + 1 + r) * 4 + r] = in_data[16*r +: 16];
        acc++;
      end
      @(negedge clk);
      if (rst_after > 0 && acc == rst_after) begin
        do_reset();
        return;
      end
    end
    in_valid = 1'b0;
    w_valid  = 1'b0;
    check_eq("stream_timeout", acc, nv);
    done_at = (nv == 0) ? sw_cyc + 2 : -1;
    pulses  = 0;
    for (t = 0; t < 300; t++) begin
      check_eq("done", done, done_at >= 0 && cyc == done_at);
      check_eq("cmd_ready_end", cmd_ready, done_at >= 0 && cyc >= done_at);
      check_eq("in_ready_drain", in_ready, 1'b0);
      check_eq("switch_drain", sys_switch_in, cyc == sw_cyc);
      check_eq("err_drain", err, 1'b0);
      if (done_at >= 0 && cyc > done_at) break;
      sys_valid_out_4 = 4'($urandom);
      if (pulses < nv) begin
        bitv = (t > 100) || ($urandom_range(0, 1) == 1);
        sys_valid_out_4[col - 1] = bitv;
        if (bitv) begin
          pulses++;
          if (pulses == nv) done_at = cyc + 2;
        end
      end
      @(negedge clk);
    end
    sys_valid_out_4 = '0;
    check_eq("drain_timeout", t < 300, 1'b1);
  endtask

  initial begin
    for (int r = 0; r < 4; r++) last_d[r] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_cmd_ready", cmd_ready, 1'b1);
    check_eq("reset_ctrl", {w_ready, in_ready, sys_switch_in, acc_w, st_v, done, err,
                            ub_rd_col_size_valid_out}, 14'h0);
    check_eq("reset_weights", wts_v, 64'h0);
    check_eq("reset_data", dat_v, 64'h0);
    check_eq("reset_col_out", ub_rd_col_size_out, 16'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    bad_cmd(0);
    bad_cmd(5);
    bad_cmd(7);
    run_tile(4, 1, 0, 0, 0);
    run_tile(4, 1, 1, 0, 0);
    run_tile(2, 3, 2, -1, 0);
    run_tile(4, 5, 2, 0, 2);
    run_tile(3, 0, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      run_tile($urandom_range(1, 4), $urandom_range(0, 6), 2, $urandom_range(0, 50), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (k == 6) bad_cmd($urandom_range(5, 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
